// File: rtl/cv32e41p_obi_data_responder.sv
// OBI data-port responder: word memory, in-order fixed-latency responses.
// Define CV32E41P_OBI_RESP_RANDOM_STALL_EN to add LFSR-driven grant stalls.
module cv32e41p_obi_data_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [2:0]  outstanding_o
);
  localparam int unsigned AW  = $clog2(MEM_WORDS);
  localparam int          MO  = int'(MAX_OUTSTANDING);
  localparam logic [3:0]  LAT = 4'(RESP_LATENCY);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] data_q [MO];
  logic [31:0] data_d [MO];
  logic [3:0]  age_q [MO];
  logic [3:0]  age_d [MO];
  logic [31:0] lst_data [MO+1];
  logic [3:0]  lst_age [MO+1];
  logic [2:0]  count_q, count_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        gnt, push, pop, lfsr_stall;
  logic [AW-1:0] idx;
  logic        unused_addr;

  assign idx         = addr_i[AW+1:2];
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
  assign gnt  = !rst_i && (count_q < 3'(MAX_OUTSTANDING))
                && !stall_i && !lfsr_stall;
  assign push = req_i && gnt;

  assign gnt_o         = gnt;
  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign outstanding_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push && we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Aged queue plus the incoming entry form one list; the head may pop
  // on the edge it arrives, so latency 1 bypasses the queue entirely.
  always_comb begin
    for (int i = 0; i <= MO; i++) begin
      lst_data[i] = '0;
      lst_age[i]  = '0;
    end
    for (int i = 0; i < MO; i++) begin
      if (i < int'(count_q)) begin
        lst_data[i] = data_q[i];
        lst_age[i]  = (age_q[i] >= LAT) ? LAT : age_q[i] + 4'd1;
      end
    end
    for (int i = 0; i <= MO; i++) begin
      if (push && i == int'(count_q)) begin
        lst_data[i] = we_i ? 32'h0 : mem_q[idx];
        lst_age[i]  = 4'd1;
      end
    end
    pop      = (lst_age[0] == LAT);
    rvalid_d = pop;
    rdata_d  = pop ? lst_data[0] : 32'h0;
    for (int i = 0; i < MO; i++) begin
      data_d[i] = pop ? lst_data[i+1] : lst_data[i];
      age_d[i]  = pop ? lst_age[i+1] : lst_age[i];
    end
    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < MO; i++) begin
        data_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      for (int i = 0; i < MO; i++) begin
        data_q[i] <= data_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

`ifdef CV32E41P_OBI_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0],
              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_stall = (lfsr_q[1:0] == 2'b00);
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign lfsr_stall  = 1'b0;
`endif
endmodule

// File: tb/tb_cv32e41p_obi_data_responder.sv
// Scoreboard bench: dut0 latency 1, dut1 latency 3, both depth 2.
// Expected responses are queued at acceptance and popped by a monitor.
module tb_cv32e41p_obi_data_responder;
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  stall = '0, req = '0, we = '0;
  logic [1:0]  gnt, rvalid;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0]  be [2];
  logic [2:0]  outs [2];
  exp_t        q0[$], q1[$];
  int          cyc = 0, compared = 0, mismatched = 0;
  int          last_due [2] = '{-10, -10};
  int          lat [2] = '{1, 3};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cv32e41p_obi_data_responder #(
    .MEM_WORDS(1024), .RESP_LATENCY(1),
    .MAX_OUTSTANDING(2), .LFSR_SEED(16'hACE1)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall[0]),
    .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
    .outstanding_o(outs[0])
  );

  cv32e41p_obi_data_responder #(
    .MEM_WORDS(1024), .RESP_LATENCY(3),
    .MAX_OUTSTANDING(2), .LFSR_SEED(16'hACE1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall[1]),
    .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
    .outstanding_o(outs[1])
  );

`ifdef CV32E41P_OBI_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else lfsr_m <= {lfsr_m[14:0],
                    lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end
`endif

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] data,
                          input int e);
    exp_t x;
    x.data = data;
    x.due  = (e + lat[d] - 1 > last_due[d]) ? e + lat[d] - 1
                                             : last_due[d] + 1;
    last_due[d] = x.due;
    if (d == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd,
                       input logic [31:0] exp, output int e);
    int n;
    n = 0;
    e = -1;
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    #1;
    while (gnt[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (gnt[d] !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL grant_timeout dut%0d: got gnt=0 expected 1", d);
      req[d] = 1'b0;
      @(negedge clk);
      return;
    end
    @(posedge clk);
    #1;
    e = cyc;
    push_exp(d, w ? 32'h0 : exp, e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t x;
    for (int d = 0; d < 2; d++) begin
      if (rvalid[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_rvalid dut%0d: got rvalid=1 expected 0", d);
        end else begin
          if (d == 0) x = q0.pop_front();
          else x = q1.pop_front();
          check($sformatf("rdata dut%0d", d), rdata[d], x.data);
          check($sformatf("resp_cycle dut%0d", d), cyc, x.due);
        end
      end else begin
        check($sformatf("rdata_idle dut%0d", d), rdata[d], 32'h0);
      end
      compared++;
      if (outs[d] > 3'd2) begin
        mismatched++;
        $display("FAIL outstanding_max dut%0d: got %0d expected <=2",
                 d, outs[d]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e0, e1, e2;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; be[d] = '0;
    end
    repeat (2) @(negedge clk);
    check("gnt_reset", {30'h0, gnt}, 32'h0);
    check("rvalid_reset", {30'h0, rvalid}, 32'h0);
    check("outs_reset", {29'h0, outs[0]}, 32'h0);
    rst = 1'b0;
    #1;
    check("gnt_after_reset", {31'h0, gnt[0]}, 32'h1);
    @(negedge clk);

    issue(0, 1'b1, 32'h100, 4'hF, 32'h12345678, 0, e0);
    issue(0, 1'b0, 32'h100, 4'hF, 0, 32'h12345678, e1);
`ifndef CV32E41P_OBI_RESP_RANDOM_STALL_EN
    check("b2b_accept", e1 - e0, 1);
`endif
    issue(0, 1'b1, 32'h104, 4'hF, 32'h11223344, 0, e0);
    issue(0, 1'b1, 32'h104, 4'b0101, 32'hAABBCCDD, 0, e0);
    issue(0, 1'b0, 32'h104, 4'hF, 0, 32'h11BB33DD, e0);
    issue(0, 1'b1, 32'h108, 4'hF, 32'h0, 0, e0);
    issue(0, 1'b1, 32'h108, 4'b1000, 32'hFFEEDDCC, 0, e0);
    issue(0, 1'b0, 32'h108, 4'hF, 0, 32'hFF000000, e0);
    issue(0, 1'b0, 32'h1100, 4'hF, 0, 32'h12345678, e0);
    idle(3);

    stall[0] = 1'b1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h100;
    be[0] = 4'hF; wdata[0] = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("gnt_stalled", {31'h0, gnt[0]}, 32'h0);
      check("outs_stalled", {29'h0, outs[0]}, 32'h0);
      @(negedge clk);
    end
    stall[0] = 1'b0;
`ifndef CV32E41P_OBI_RESP_RANDOM_STALL_EN
    #1;
    check("gnt_unstall", {31'h0, gnt[0]}, 32'h1);
`endif
    issue(0, 1'b0, 32'h100, 4'hF, 0, 32'h12345678, e0);
    idle(3);

    issue(1, 1'b1, 32'h200, 4'hF, 32'hCAFEF00D, 0, e0);
    idle(5);
    issue(1, 1'b0, 32'h200, 4'hF, 0, 32'hCAFEF00D, e0);
    issue(1, 1'b0, 32'h204, 4'hF, 0, 32'h0, e1);
`ifndef CV32E41P_OBI_RESP_RANDOM_STALL_EN
    check("outs_full", {29'h0, outs[1]}, 32'h2);
    check("gnt_full", {31'h0, gnt[1]}, 32'h0);
`endif
    req[1] = 1'b0;
    issue(1, 1'b1, 32'h204, 4'hF, 32'h0, 0, e2);
    idle(6);
    issue(1, 1'b0, 32'h200, 4'hF, 0, 32'hCAFEF00D, e0);
    issue(1, 1'b0, 32'h200, 4'hF, 0, 32'hCAFEF00D, e1);
    issue(1, 1'b0, 32'h204, 4'hF, 0, 32'h0, e2);
`ifndef CV32E41P_OBI_RESP_RANDOM_STALL_EN
    check("second_accept", e1 - e0, 1);
    check("third_accept", e2 - e0, 3);
`endif
    idle(8);

    issue(1, 1'b0, 32'h200, 4'hF, 0, 32'hCAFEF00D, e0);
    issue(1, 1'b0, 32'h200, 4'hF, 0, 32'hCAFEF00D, e1);
`ifndef CV32E41P_OBI_RESP_RANDOM_STALL_EN
    check("outs_pre_reset", {29'h0, outs[1]}, 32'h2);
`endif
    req = '0;
    rst = 1'b1;
    #1;
    check("rvalid_in_reset", {31'h0, rvalid[1]}, 32'h0);
    check("outs_in_reset", {29'h0, outs[1]}, 32'h0);
    check("gnt_in_reset", {31'h0, gnt[1]}, 32'h0);
    q1.delete();
    last_due[1] = -10;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(8);
    issue(1, 1'b0, 32'h200, 4'hF, 0, 32'hCAFEF00D, e0);
    idle(6);

`ifdef CV32E41P_OBI_RESP_RANDOM_STALL_EN
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h100; be[0] = 4'hF;
    for (int i = 0; i < 64; i++) begin
      #1;
      check("lfsr_gnt", {31'h0, gnt[0]},
            {31'h0, (lfsr_m[1:0] != 2'b00)});
      if (gnt[0]) begin
        @(posedge clk);
        #1;
        push_exp(0, 32'h12345678, cyc);
      end
      @(negedge clk);
    end
    idle(4);
`endif

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
